// File: rtl/seq_digit_multiplier_pkg.sv
// rtl/seq_digit_multiplier_pkg.sv - state encoding and sizing helpers for the digit-serial multiplier
package seq_digit_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Digits per operand; guarded so an illegal DIGIT reaches the elaboration check instead of dividing by zero.
  function automatic int calc_k(input int width, input int digit);
    return (digit < 1) ? 1 : width / digit;
  endfunction

  function automatic int calc_idx_w(input int width, input int digit);
    int k;
    k = calc_k(width, digit);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/digit_multiplier.sv
// rtl/digit_multiplier.sv - combinational unsigned DIGIT x DIGIT multiplier
module digit_multiplier #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0]   x_i,
  input  logic [DIGIT-1:0]   y_i,
  output logic [2*DIGIT-1:0] p_o
);

  assign p_o = {{DIGIT{1'b0}}, x_i} * {{DIGIT{1'b0}}, y_i};

endmodule

// File: rtl/seq_digit_multiplier.sv
// rtl/seq_digit_multiplier.sv - digit-serial multiply/accumulate, one partial product per clock
module seq_digit_multiplier
  import seq_digit_multiplier_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               acc_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               overflow
);

  localparam int K  = calc_k(WIDTH, DIGIT);
  localparam int IW = calc_idx_w(WIDTH, DIGIT);
  localparam logic [IW-1:0] LAST = IW'(K - 1);

  generate
    if ((DIGIT < 1) ? 1'b1 : ((WIDTH % DIGIT) != 0)) begin : g_bad_params
      $error("seq_digit_multiplier: DIGIT must be >= 1 and divide WIDTH");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [IW-1:0]      i_q, i_d, j_q, j_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               ovf_q, ovf_d;

  logic [DIGIT-1:0]   a_dig, b_dig;
  logic [2*DIGIT-1:0] pp;
  logic [2*WIDTH-1:0] pp_ext, pp_shift;
  logic [2*WIDTH:0]   sum;

  assign a_dig = a_q[32'(i_q) * DIGIT +: DIGIT];
  assign b_dig = b_q[32'(j_q) * DIGIT +: DIGIT];

  digit_multiplier #(.DIGIT(DIGIT)) u_digit_mul (
    .x_i (a_dig),
    .y_i (b_dig),
    .p_o (pp)
  );

  always_comb begin
    pp_ext = '0;
    pp_ext[2*DIGIT-1:0] = pp;
  end

  // Partial product weight is the sum of both digit positions; the extra sum bit is the step's carry-out.
  assign pp_shift = pp_ext << (DIGIT * (32'(i_q) + 32'(j_q)));
  assign sum      = {1'b0, acc_q} + {1'b0, pp_shift};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          i_d     = '0;
          j_d     = '0;
          ovf_d   = 1'b0;
          if (!acc_mode) begin
            acc_d = '0;
          end
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = sum[2*WIDTH-1:0];
        ovf_d = ovf_q | sum[2*WIDTH];
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            i_d     = '0;
            state_d = DONE;
          end else begin
            i_d = i_q + IW'(1);
          end
        end else begin
          j_d = j_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = acc_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_digit_multiplier.sv
// tb/tb_seq_digit_multiplier.sv - scoreboard bench for seq_digit_multiplier
module tb_seq_digit_multiplier;

  localparam int K2 = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, acc_mode = 1'b0, out_ready = 1'b0;
  logic [7:0]  a_in = '0, b_in = '0;
  logic        in_ready, out_valid, overflow;
  logic [15:0] product;

  logic        d1_in_valid = 1'b0, d1_acc_mode = 1'b0, d1_out_ready = 1'b0;
  logic [7:0]  d1_a = '0, d1_b = '0;
  logic        d1_in_ready, d1_out_valid, d1_overflow;
  logic [15:0] d1_product;

  always #5 clk = ~clk;

  seq_digit_multiplier #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .acc_mode(acc_mode), .out_valid(out_valid),
    .out_ready(out_ready), .product(product), .overflow(overflow)
  );

  seq_digit_multiplier #(.WIDTH(8), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .a_in(d1_a), .b_in(d1_b), .acc_mode(d1_acc_mode), .out_valid(d1_out_valid),
    .out_ready(d1_out_ready), .product(d1_product), .overflow(d1_overflow)
  );

  typedef struct {
    logic [15:0] prod;
    logic        ovf;
    int          acc_cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] model_acc = '0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Monitor: checks latency on the rising edge of out_valid and the result on each handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_valid = 1'b0;
      end else begin
        if (out_valid && !prev_valid) begin
          if (sb_q.size() == 0) fail_now("unexpected_out_valid");
          else check("latency", cyc - sb_q[0].acc_cyc, K2);
        end
        if (out_valid && out_ready && sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("product", product, e.prod);
          check("overflow", overflow, e.ovf);
        end
        prev_valid = out_valid;
      end
    end
  end

  // Reference: the result is the plain integer product, or the previous result plus it, modulo 2^16.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic m);
    int          n;
    logic [16:0] s;
    exp_t        e;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      fail_now("issue_wait_in_ready");
      return;
    end
    a_in = a; b_in = b; acc_mode = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (m) s = {1'b0, model_acc} + a * b;
    else   s = a * b;
    model_acc = s[15:0];
    e.prod    = s[15:0];
    e.ovf     = m ? s[16] : 1'b0;
    e.acc_cyc = cyc;
    sb_q.push_back(e);
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (!out_valid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    ok = out_valid;
    if (!ok) fail_now("wait_out_valid");
  endtask

  task automatic collect(input int hold, input bit early);
    bit ok;
    if (early) out_ready = 1'b1;
    wait_valid(ok);
    if (!ok) return;
    if (!early) begin
      repeat (hold) @(posedge clk);
      #1;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    model_acc = '0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_product", product, 16'h0000);
    check("rst_overflow", overflow, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit          ok;
    int          n;
    logic [15:0] snap;
    repeat (2) @(posedge clk);
    #1;
    check("init_in_ready", in_ready, 1);
    check("init_out_valid", out_valid, 0);
    check("init_product", product, 16'h0000);
    check("init_overflow", overflow, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(8'hFF, 8'hFF, 1'b0); collect(0, 1'b0);
    issue(8'h02, 8'h03, 1'b1); collect(2, 1'b0);
    issue(8'hFF, 8'hFF, 1'b0); collect(0, 1'b0);
    issue(8'hFF, 8'hFF, 1'b1); collect(1, 1'b0);
    issue(8'h01, 8'h01, 1'b0); collect(0, 1'b1);

    async_reset();

    issue(8'hFF, 8'hFF, 1'b0);
    wait_valid(ok);
    if (ok) begin
      snap = model_acc;
      for (int c = 0; c < 10; c++) begin
        in_valid = ~in_valid;
        a_in = 8'($urandom); b_in = 8'($urandom); acc_mode = 1'($urandom);
        @(posedge clk); #1;
        check("bp_product", product, snap);
        check("bp_overflow", overflow, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_release_in_ready", in_ready, 1);
      check("bp_release_out_valid", out_valid, 0);
    end
    issue(8'h02, 8'h03, 1'b1); collect(0, 1'b0);

    issue(8'h55, 8'h77, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    async_reset();
    issue(8'h12, 8'h34, 1'b1); collect(0, 1'b0);

    for (int t = 0; t < 20; t++) begin
      issue(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      collect($urandom_range(0, 3), $urandom_range(0, 3) == 0);
    end

    d1_a = 8'hFF; d1_b = 8'hFF; d1_acc_mode = 1'b0; d1_in_valid = 1'b1;
    @(posedge clk); #1;
    d1_in_valid = 1'b0;
    n = 0;
    while (!d1_out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("d1_latency", n, 64);
    check("d1_product", d1_product, 16'hFE01);
    check("d1_overflow", d1_overflow, 0);
    d1_out_ready = 1'b1;
    @(posedge clk); #1;
    d1_out_ready = 1'b0;
    check("d1_in_ready", d1_in_ready, 1);

    n = 0;
    while (sb_q.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() > 0) fail_now("scoreboard_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_digit_multiplier.md
SEQ_DIGIT_MULTIPLIER -- requirements
Module: seq_digit_multiplier

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits.
REQ-002 Parameter DIGIT, default 2, digit width in bits processed per partial product.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  operand set offered.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 a_in  input  WIDTH  unsigned multiplicand.
REQ-008 b_in  input  WIDTH  unsigned multiplier.
REQ-009 acc_mode  input  1  0 = product replaces the result; 1 = product is added to the previous result; sampled with the operands.
REQ-010 out_valid  output  1  result complete and held.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 product  output  2*WIDTH  accumulator register, driven directly.
REQ-013 overflow  output  1  carry out of bit 2*WIDTH-1 during the last transaction.

Function
REQ-014 Constant K = WIDTH/DIGIT; elaboration SHALL fail unless DIGIT >= 1 and WIDTH mod DIGIT = 0.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE; in_ready = (state==IDLE) and out_valid = (state==DONE), both decoded from registered state.
REQ-016 IDLE with in_valid=1 SHALL accept the operand set on that edge.
  Capture a_in, b_in and acc_mode.
  Zero digit indices i and j.
  Clear overflow.
  Clear the accumulator if acc_mode=0; keep it if acc_mode=1.
  Enter RUN.
REQ-017 Each RUN cycle SHALL perform one accumulation step.
  Add digit_product(A[i], B[j]) << DIGIT*(i+j) to the accumulator, modulo 2^(2*WIDTH).
  OR the carry-out of the add into overflow.
  Advance j; when j wraps from K-1 to 0, advance i.
REQ-018 RUN SHALL last exactly K*K cycles, then enter DONE; out_valid SHALL rise K*K edges after the accepting edge (16 for the defaults).
REQ-019 DONE SHALL hold product and overflow stable until out_ready=1, then return to IDLE on that edge; the operand-accept edge and the result-handshake edge never coincide.
REQ-020 in_valid SHALL be ignored in RUN and DONE; out_ready SHALL be ignored outside DONE.
REQ-021 With acc_mode=0, overflow SHALL end at 0, since a*b < 2^(2*WIDTH).
REQ-022 Intermediate accumulator values SHALL be visible on product during RUN; consumers use product only while out_valid=1.
REQ-023 The result SHALL be retained across IDLE indefinitely, so that a later acc_mode=1 transaction continues from it.

Reset
REQ-024 rst_n low SHALL asynchronously force state=IDLE, accumulator=0, overflow=0, i=j=0 and operand registers=0, giving in_ready=1, out_valid=0, product=0, overflow=0.
REQ-025 Reset asserted during RUN or DONE SHALL abandon the transaction with no residual effect; the first transaction after reset with acc_mode=1 accumulates onto 0.

Structure
REQ-026 A shared package SHALL hold the state enumeration (IDLE, RUN, DONE) and a function computing K and the index width from WIDTH and DIGIT.
REQ-027 One sub-module, digit_multiplier, SHALL be used: combinational, parametrised DIGIT x DIGIT, unsigned, 2*DIGIT-bit result. All sequencing, shifting and accumulation stay in seq_digit_multiplier.

Verification
REQ-028 Reset: drive rst_n=0 asynchronously mid-cycle -> immediately in_ready=1, out_valid=0, product=16'h0000, overflow=0.
REQ-029 Basic multiply (defaults): a=8'hFF, b=8'hFF, acc_mode=0 -> out_valid exactly 16 edges after accept, product=16'hFE01, overflow=0.
REQ-030 Accumulate: after REQ-029, a=8'h02, b=8'h03, acc_mode=1 -> product=16'hFE07, overflow=0.
REQ-031 Overflow: after REQ-029, a=8'hFF, b=8'hFF, acc_mode=1 -> product=16'hFC02, overflow=1; a following acc_mode=0 with a=1, b=1 -> product=16'h0001, overflow=0.
REQ-032 Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid -> product, overflow and out_valid stable, in_ready=0, no operand captured; raising out_ready -> IDLE the next edge.
REQ-033 Reset mid-run and alternate parameters:
  Assert rst_n=0 at RUN cycle 7, release, then a=8'h12, b=8'h34, acc_mode=1 -> product=16'h03A8.
  Repeat REQ-029 with WIDTH=8, DIGIT=1 -> latency 64 edges, product=16'hFE01.
